// File: rtl/control_sequencer_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer_param                                                    |
// | One-hot T-state ring plus opcode decode driving the 12-bit SAP control word.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_sequencer_param #(
  parameter int RING_W    = 6,
  parameter bit EARLY_END = 1'b1,
  parameter int OPCODE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_en,
  input  logic [OPCODE_W-1:0] from_IR,
  output logic [11:0]         ctrl_word,
  output logic [RING_W-1:0]   t_state,
  output logic                instr_done,
  output logic                hlt
);

  localparam logic [3:0] c_op_nop = 4'b0000;
  localparam logic [3:0] c_op_add = 4'b0001;
  localparam logic [3:0] c_op_sub = 4'b0010;
  localparam logic [3:0] c_op_ldb = 4'b0011;
  localparam logic [3:0] c_op_lda = 4'b0111;
  localparam logic [3:0] c_op_out = 4'b1110;
  localparam logic [3:0] c_op_hlt = 4'b1111;

  generate
    if (RING_W < 6 || RING_W > 16) begin : g_bad_ring_w
      $error("control_sequencer_param: RING_W must be in 6..16");
    end
    if (OPCODE_W < 4) begin : g_bad_opcode_w
      $error("control_sequencer_param: OPCODE_W must be at least 4");
    end
  endgenerate

  logic [RING_W-1:0] ring_q, ring_d;
  logic [3:0]        op_q, op_d;
  logic              hlt_q, hlt_d;
  logic [3:0]        w_live_op;
  logic              w_last;
  logic              w_adv;
  logic [11:0]       w_ctrl;

  // Unknown, undriven or wide opcodes all collapse to NOP, keeping X out of the decode.
  always_comb begin
    w_live_op = c_op_nop;
    case (from_IR)
      OPCODE_W'(c_op_add): w_live_op = c_op_add;
      OPCODE_W'(c_op_sub): w_live_op = c_op_sub;
      OPCODE_W'(c_op_ldb): w_live_op = c_op_ldb;
      OPCODE_W'(c_op_lda): w_live_op = c_op_lda;
      OPCODE_W'(c_op_out): w_live_op = c_op_out;
      OPCODE_W'(c_op_hlt): w_live_op = c_op_hlt;
      default:             w_live_op = c_op_nop;
    endcase
  end

  // T3 must use the live opcode: the register only captures on leaving T3.
  always_comb begin
    w_last = 1'b0;
    if (ring_q[2])      w_last = (w_live_op == c_op_nop);
    else if (ring_q[3]) w_last = (op_q == c_op_out) || (op_q == c_op_hlt);
    else if (ring_q[4]) w_last = (op_q == c_op_lda) || (op_q == c_op_ldb);
    else if (ring_q[5]) w_last = (op_q == c_op_add) || (op_q == c_op_sub);
  end

  assign w_adv = run_en && !hlt_q;

  always_comb begin
    ring_d = ring_q;
    op_d   = op_q;
    hlt_d  = hlt_q;
    if (w_adv) begin
      if (ring_q[2]) op_d = w_live_op;
      if (ring_q[3] && (op_q == c_op_hlt)) hlt_d = 1'b1;
      else if (EARLY_END && w_last)        ring_d = {{(RING_W-1){1'b0}}, 1'b1};
      else                                 ring_d = {ring_q[RING_W-2:0], ring_q[RING_W-1]};
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      ring_q <= {{(RING_W-1){1'b0}}, 1'b1};
      op_q   <= c_op_nop;
      hlt_q  <= 1'b0;
    end else begin
      ring_q <= ring_d;
      op_q   <= op_d;
      hlt_q  <= hlt_d;
    end
  end

  always_comb begin
    w_ctrl = 12'h000;
    if (ring_q[0])      w_ctrl = 12'h600;
    else if (ring_q[1]) w_ctrl = 12'h800;
    else if (ring_q[2]) w_ctrl = 12'h180;
    else if (ring_q[3]) begin
      case (op_q)
        c_op_lda, c_op_add, c_op_sub, c_op_ldb: w_ctrl = 12'h240;
        c_op_out:                               w_ctrl = 12'h011;
        default:                                w_ctrl = 12'h000;
      endcase
    end else if (ring_q[4]) begin
      case (op_q)
        c_op_lda:                     w_ctrl = 12'h120;
        c_op_add, c_op_sub, c_op_ldb: w_ctrl = 12'h102;
        default:                      w_ctrl = 12'h000;
      endcase
    end else if (ring_q[5]) begin
      case (op_q)
        c_op_add: w_ctrl = 12'h024;
        c_op_sub: w_ctrl = 12'h02C;
        default:  w_ctrl = 12'h000;
      endcase
    end
  end

  assign ctrl_word  = (reset && w_adv) ? w_ctrl : 12'h000;
  assign instr_done = reset && w_adv && (EARLY_END ? w_last : ring_q[RING_W-1]);
  assign t_state    = ring_q;
  assign hlt        = hlt_q;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_sequencer_param                                                 |
// | Scoreboard bench: default instance plus an 8-state, no-early-end instance. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_control_sequencer_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic [3:0]  from_IR;
  logic [11:0] cw0, cw8;
  logic [5:0]  ts0;
  logic [7:0]  ts8;
  logic        done0, done8, hlt0, hlt8;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    bit          sel;
    string       tag;
    logic [29:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  control_sequencer_param dut0 (
    .clk(clk), .reset(reset), .run_en(run_en), .from_IR(from_IR),
    .ctrl_word(cw0), .t_state(ts0), .instr_done(done0), .hlt(hlt0)
  );

  control_sequencer_param #(.RING_W(8), .EARLY_END(1'b0), .OPCODE_W(4)) dut8 (
    .clk(clk), .reset(reset), .run_en(run_en), .from_IR(from_IR),
    .ctrl_word(cw8), .t_state(ts8), .instr_done(done8), .hlt(hlt8)
  );

  wire [29:0] obs0 = {cw0, 10'd0, ts0, done0, hlt0};
  wire [29:0] obs8 = {cw8, 8'd0, ts8, done8, hlt8};

  function automatic void exp_push(bit s, string tag, logic [11:0] c, logic [15:0] t,
                                   logic d, logic h);
    exp_t e;
    e.sel = s;
    e.tag = tag;
    e.v   = {c, t, d, h};
    sb.push_back(e);
  endfunction

  // Releases reset just after a negedge so T1 is seen at the following posedge.
  task automatic apply_reset();
    run_en = 1'b1;
    reset  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [29:0] got;
    run_en  = 1'b1;
    from_IR = 4'bxxxx;
    reset   = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_push(1'b0, "reset_dut0", 12'h000, 16'h0001, 1'b0, 1'b0);
    exp_push(1'b1, "reset_dut8", 12'h000, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  // Opcode stays X through T1/T2 and only becomes LDA on entering T3.
  task automatic test_lda();
    logic [11:0] c[6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h600};
    logic [15:0] t[6] = '{16'h01, 16'h02, 16'h04, 16'h08, 16'h10, 16'h01};
    exp_t e;
    logic [29:0] got;
    for (int i = 0; i < 6; i++) exp_push(1'b0, $sformatf("lda[%0d]", i), c[i], t[i], i == 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin @(negedge clk); #1; from_IR = 4'b0111; end
      @(posedge clk); #1;
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
  endtask

  task automatic test_sub_ring8();
    logic [11:0] c[9] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C,
                          12'h000, 12'h000, 12'h600};
    logic [15:0] t[9] = '{16'h01, 16'h02, 16'h04, 16'h08, 16'h10, 16'h20,
                          16'h40, 16'h80, 16'h01};
    exp_t e;
    logic [29:0] got;
    from_IR = 4'b0010;
    apply_reset();
    for (int i = 0; i < 9; i++) exp_push(1'b1, $sformatf("sub8[%0d]", i), c[i], t[i], i == 7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
  endtask

  // IR switches to OUT while ADD is executing; ADD must finish from the captured opcode.
  task automatic test_back_to_back();
    logic [11:0] c[11] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024,
                           12'h600, 12'h800, 12'h180, 12'h011, 12'h600};
    logic [15:0] t[11] = '{16'h01, 16'h02, 16'h04, 16'h08, 16'h10, 16'h20,
                           16'h01, 16'h02, 16'h04, 16'h08, 16'h01};
    exp_t e;
    logic [29:0] got;
    from_IR = 4'b0001;
    apply_reset();
    for (int i = 0; i < 11; i++)
      exp_push(1'b0, $sformatf("b2b[%0d]", i), c[i], t[i], (i == 5) || (i == 9), 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin @(negedge clk); #1; from_IR = 4'b1110; end
      @(posedge clk); #1;
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    logic [29:0] got;
    from_IR = 4'b1111;
    apply_reset();
    exp_push(1'b0, "hlt_t1", 12'h600, 16'h01, 1'b0, 1'b0);
    exp_push(1'b0, "hlt_t2", 12'h800, 16'h02, 1'b0, 1'b0);
    exp_push(1'b0, "hlt_t3", 12'h180, 16'h04, 1'b0, 1'b0);
    exp_push(1'b0, "hlt_t4", 12'h000, 16'h08, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) exp_push(1'b0, $sformatf("hlt_frozen[%0d]", i), 12'h000, 16'h08, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
    reset = 1'b0;
    #1;
    exp_push(1'b0, "hlt_cleared", 12'h000, 16'h01, 1'b0, 1'b0);
    e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
    if (got !== e.v) begin
      n_err++;
      $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    exp_push(1'b0, "hlt_refetch", 12'h600, 16'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
    if (got !== e.v) begin
      n_err++;
      $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
    end
  endtask

  // Pause entered right after the ring reaches T2; exactly one Cp sample after resume.
  task automatic test_run_pause();
    logic [11:0] c[9] = '{12'h600, 12'h000, 12'h000, 12'h000, 12'h800, 12'h180,
                          12'h240, 12'h120, 12'h600};
    logic [15:0] t[9] = '{16'h01, 16'h02, 16'h02, 16'h02, 16'h02, 16'h04,
                          16'h08, 16'h10, 16'h01};
    exp_t e;
    logic [29:0] got;
    from_IR = 4'b0111;
    apply_reset();
    for (int i = 0; i < 9; i++) exp_push(1'b0, $sformatf("pause[%0d]", i), c[i], t[i], i == 7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 1) begin @(negedge clk); #1; run_en = 1'b0; end
      if (i == 4) begin @(negedge clk); #1; run_en = 1'b1; end
      @(posedge clk); #1;
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] c[5] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102};
    logic [15:0] t[5] = '{16'h01, 16'h02, 16'h04, 16'h08, 16'h10};
    exp_t e;
    logic [29:0] got;
    from_IR = 4'b0001;
    apply_reset();
    for (int i = 0; i < 5; i++) exp_push(1'b0, $sformatf("rmid[%0d]", i), c[i], t[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
      if (got !== e.v) begin
        n_err++;
        $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
      end
    end
    reset = 1'b0;
    #1;
    exp_push(1'b0, "rmid_async", 12'h000, 16'h01, 1'b0, 1'b0);
    e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
    if (got !== e.v) begin
      n_err++;
      $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    exp_push(1'b0, "rmid_refetch", 12'h600, 16'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front(); got = e.sel ? obs8 : obs0; n_vec++;
    if (got !== e.v) begin
      n_err++;
      $display("FAIL %s: got {cw,ts,done,hlt}=%h required %h", e.tag, got, e.v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lda();
    test_sub_ring8();
    test_back_to_back();
    test_halt();
    test_run_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
